mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control_if.sv | 34 +++
 rtl/mc_control.sv | 133 +++++++++++++
 tb/tb_mc_control.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller owns the strobes and status; the datapath supplies decode fields and acks.
interface mc_control_if;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        zero;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        mem_addr_sel;
   logic        ir_we;
   logic        pc_we;
   logic        pc_src;
   logic        tgt_we;
   logic        alu_src_b;
   logic [1:0]  alu_op;
   logic        reg_we;
   logic        wb_sel;
   logic        illegal;
   logic [2:0]  state;
   logic [31:0] instret;

   modport master (
      input  opcode, funct3, zero, mem_ready,
      output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, tgt_we,
             alu_src_b, alu_op, reg_we, wb_sel, illegal, state, instret
   );

   modport slave (
      output opcode, funct3, zero, mem_ready,
      input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, tgt_we,
             alu_src_b, alu_op, reg_we, wb_sel, illegal, state, instret
   );
endinterface

// File: rtl/mc_control.sv
// Multicycle RV32 subset controller: fetch/decode/exec/mem/writeback sequencing,
// sticky trap on unsupported encodings, and a retired-instruction counter.
//
// state  | meaning
// FETCH  | request instruction word, wait for mem_ready
// DECODE | legality check, latch branch target
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data access for lw/sw, wait for mem_ready
// WB     | register-file write
// TRAP   | unsupported instruction, held until rst
module mc_control (
   input logic       clk,
   input logic       rst,
   mc_control_if.master bus
);
   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WB     = 3'd4;
   localparam logic [2:0] TRAP   = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [31:0] instret_q;
   logic        is_lw, is_sw, is_br, is_r, is_i, legal, br_taken, retire;
   logic        s_mem_req, s_mem_we, s_ir_we, s_pc_we, s_tgt_we, s_reg_we;
   logic        s_addr_sel, s_pc_src, s_src_b, s_wb_sel;
   logic [1:0]  s_alu_op;

   assign is_lw = (bus.opcode == 7'b0000011);
   assign is_sw = (bus.opcode == 7'b0100011);
   assign is_br = (bus.opcode == 7'b1100011);
   assign is_r  = (bus.opcode == 7'b0110011);
   assign is_i  = (bus.opcode == 7'b0010011);
   assign legal = is_lw | is_sw | is_r | is_i |
                  (is_br & ((bus.funct3 == 3'b000) | (bus.funct3 == 3'b001)));
   assign br_taken = ((bus.funct3 == 3'b000) &  bus.zero) |
                     ((bus.funct3 == 3'b001) & ~bus.zero);

   always_comb begin
      state_d    = state_q;
      s_mem_req  = 1'b0;
      s_mem_we   = 1'b0;
      s_addr_sel = 1'b0;
      s_ir_we    = 1'b0;
      s_pc_we    = 1'b0;
      s_pc_src   = 1'b0;
      s_tgt_we   = 1'b0;
      s_src_b    = 1'b0;
      s_alu_op   = 2'b00;
      s_reg_we   = 1'b0;
      s_wb_sel   = 1'b0;
      retire     = 1'b0;
      case (state_q)
         FETCH: begin
            s_mem_req = 1'b1;
            if (bus.mem_ready) begin
               s_ir_we = 1'b1;
               s_pc_we = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            s_tgt_we = 1'b1;
            state_d  = legal ? EXEC : TRAP;
         end
         EXEC: begin
            if (is_lw | is_sw) begin
               s_src_b = 1'b1;
               state_d = MEM;
            end else if (is_br) begin
               s_alu_op = 2'b01;
               s_pc_we  = br_taken;
               s_pc_src = br_taken;
               retire   = 1'b1;
               state_d  = FETCH;
            end else if (is_r | is_i) begin
               s_src_b  = is_i;
               s_alu_op = 2'b10;
               state_d  = WB;
            end else begin
               state_d = FETCH;
            end
         end
         MEM: begin
            s_mem_req  = 1'b1;
            s_addr_sel = 1'b1;
            s_src_b    = 1'b1;
            s_mem_we   = is_sw;
            if (bus.mem_ready) begin
               retire  = is_sw;
               state_d = is_sw ? FETCH : WB;
            end
         end
         WB: begin
            s_reg_we = 1'b1;
            s_wb_sel = is_lw;
            s_src_b  = is_lw | is_sw | is_i;
            s_alu_op = is_br ? 2'b01 : ((is_r | is_i) ? 2'b10 : 2'b00);
            retire   = 1'b1;
            state_d  = FETCH;
         end
         TRAP:    state_d = TRAP;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH;
         instret_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (retire) instret_q <= instret_q + 32'd1;
      end
   end

   // Strobes are masked by rst so nothing fires while the controller is held.
   assign bus.mem_req      = s_mem_req & ~rst;
   assign bus.mem_we       = s_mem_we  & ~rst;
   assign bus.ir_we        = s_ir_we   & ~rst;
   assign bus.pc_we        = s_pc_we   & ~rst;
   assign bus.tgt_we       = s_tgt_we  & ~rst;
   assign bus.reg_we       = s_reg_we  & ~rst;
   assign bus.mem_addr_sel = s_addr_sel;
   assign bus.pc_src       = s_pc_src;
   assign bus.alu_src_b    = s_src_b;
   assign bus.alu_op       = s_alu_op;
   assign bus.wb_sel       = s_wb_sel;
   assign bus.illegal      = (state_q == TRAP);
   assign bus.state        = state_q;
   assign bus.instret      = instret_q;
endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: per-cycle expected outputs are queued with the
// mem_ready stimulus for each instruction and compared as the controller steps.
module tb_mc_control;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mc_control_if bus();
   mc_control dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [2:0] st;
      logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, tgt_we, alu_src_b;
      logic [1:0] alu_op;
      logic       reg_we, wb_sel, illegal;
   } obs_t;

   localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_BR = 7'b1100011;
   localparam logic [6:0] OP_R  = 7'b0110011, OP_I  = 7'b0010011, OP_LUI = 7'b0110111;

   obs_t        exp_q[$];
   logic        mr_q[$];
   int          checks = 0;
   int          passed = 0;
   logic [31:0] exp_instret = 32'd0;

   function automatic obs_t blank(input logic [2:0] st);
      obs_t e;
      e = '0;
      e.st = st;
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t a;
      a.st = bus.state;            a.mem_req = bus.mem_req;     a.mem_we = bus.mem_we;
      a.mem_addr_sel = bus.mem_addr_sel; a.ir_we = bus.ir_we;   a.pc_we = bus.pc_we;
      a.pc_src = bus.pc_src;       a.tgt_we = bus.tgt_we;       a.alu_src_b = bus.alu_src_b;
      a.alu_op = bus.alu_op;       a.reg_we = bus.reg_we;       a.wb_sel = bus.wb_sel;
      a.illegal = bus.illegal;
      return a;
   endfunction

   task automatic push(input obs_t e, input logic mr);
      exp_q.push_back(e);
      mr_q.push_back(mr);
   endtask

   // Builds the expected cycle-by-cycle trace of one legal instruction.
   task automatic push_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input int fwait, input int mwait);
      obs_t e;
      logic taken;
      for (int i = 0; i < fwait; i++) begin
         e = blank(3'd0); e.mem_req = 1'b1; push(e, 1'b0);
      end
      e = blank(3'd0); e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; push(e, 1'b1);
      e = blank(3'd1); e.tgt_we = 1'b1; push(e, 1'b1);
      e = blank(3'd2);
      if (op == OP_BR) begin
         taken = ((f3 == 3'b000) && z) || ((f3 == 3'b001) && !z);
         e.alu_op = 2'b01; e.pc_we = taken; e.pc_src = taken;
         push(e, 1'b1);
         exp_instret++;
         return;
      end
      if (op == OP_LW || op == OP_SW) begin
         e.alu_src_b = 1'b1; push(e, 1'b1);
         for (int i = 0; i <= mwait; i++) begin
            e = blank(3'd3); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.alu_src_b = 1'b1;
            e.mem_we = (op == OP_SW);
            push(e, (i == mwait));
         end
         if (op == OP_SW) begin
            exp_instret++;
            return;
         end
         e = blank(3'd4); e.reg_we = 1'b1; e.wb_sel = 1'b1; e.alu_src_b = 1'b1;
         push(e, 1'b1);
      end else begin
         e.alu_op = 2'b10; e.alu_src_b = (op == OP_I); push(e, 1'b1);
         e = blank(3'd4); e.reg_we = 1'b1; e.alu_op = 2'b10; e.alu_src_b = (op == OP_I);
         push(e, 1'b1);
      end
      exp_instret++;
   endtask

   task automatic drain(input string name);
      obs_t e, a;
      logic m;
      int   cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         m = mr_q.pop_front();
         @(negedge clk);
         bus.mem_ready = m;
         #1;
         a = sample();
         checks++;
         if (a !== e)
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, a, e);
         else
            passed++;
         cyc++;
      end
   endtask

   task automatic check_fetch_instret(input string name);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (bus.state !== 3'd0 || bus.instret !== exp_instret)
         $display("FAIL %s: state %0d instret %h, expected state 0 instret %h",
                  name, bus.state, bus.instret, exp_instret);
      else
         passed++;
   endtask

   task automatic run(input string name, input logic [6:0] op, input logic [2:0] f3,
                      input logic z, input int fwait, input int mwait);
      bus.opcode = op; bus.funct3 = f3; bus.zero = z;
      push_instr(op, f3, z, fwait, mwait);
      drain(name);
      check_fetch_instret({name, "_retire"});
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.mem_ready = 1'b1; bus.opcode = OP_R; bus.funct3 = 3'b000; bus.zero = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.tgt_we, bus.reg_we} !== 6'b0 ||
          bus.state !== 3'd0 || bus.instret !== 32'd0 || bus.illegal !== 1'b0)
         $display("FAIL reset_hold: strobes %b state %0d instret %h illegal %b, expected all 0",
                  {bus.mem_req, bus.mem_we, bus.ir_we, bus.pc_we, bus.tgt_we, bus.reg_we},
                  bus.state, bus.instret, bus.illegal);
      else passed++;
      rst = 1'b0; bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (bus.mem_req !== 1'b1) $display("FAIL first_fetch_req: mem_req %b expected 1", bus.mem_req);
      else passed++;
      exp_instret = 32'd0;
   endtask

   task automatic test_trap(input string name, input logic [6:0] op, input logic [2:0] f3);
      obs_t e;
      bus.opcode = op; bus.funct3 = f3; bus.zero = 1'b0;
      e = blank(3'd0); e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; push(e, 1'b1);
      e = blank(3'd1); e.tgt_we = 1'b1; push(e, 1'b0);
      for (int i = 0; i < 12; i++) begin
         e = blank(3'd5); e.illegal = 1'b1; push(e, logic'(i % 2));
      end
      drain(name);
      @(negedge clk);
      rst = 1'b1; #1;
      checks++;
      if ({bus.mem_req, bus.ir_we, bus.pc_we, bus.tgt_we, bus.reg_we} !== 5'b0)
         $display("FAIL %s_rst_strobes: got %b expected 0", name,
                  {bus.mem_req, bus.ir_we, bus.pc_we, bus.tgt_we, bus.reg_we});
      else passed++;
      @(negedge clk);
      rst = 1'b0; bus.mem_ready = 1'b0; #1;
      exp_instret = 32'd0;
      checks++;
      if (bus.state !== 3'd0 || bus.illegal !== 1'b0 || bus.instret !== 32'd0 || bus.mem_req !== 1'b1)
         $display("FAIL %s_exit: state %0d illegal %b instret %h mem_req %b, expected 0 0 0 1",
                  name, bus.state, bus.illegal, bus.instret, bus.mem_req);
      else passed++;
   endtask

   task automatic test_rst_mid_mem();
      obs_t e;
      bus.opcode = OP_LW; bus.funct3 = 3'b010; bus.zero = 1'b0;
      e = blank(3'd0); e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; push(e, 1'b1);
      e = blank(3'd1); e.tgt_we = 1'b1; push(e, 1'b0);
      e = blank(3'd2); e.alu_src_b = 1'b1; push(e, 1'b0);
      e = blank(3'd3); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.alu_src_b = 1'b1; push(e, 1'b0);
      drain("rst_mid_mem_pre");
      @(negedge clk);
      rst = 1'b1; bus.mem_ready = 1'b1; #1;
      checks++;
      if (bus.mem_req !== 1'b0 || bus.reg_we !== 1'b0)
         $display("FAIL rst_mid_mem_hold: mem_req %b reg_we %b expected 0 0", bus.mem_req, bus.reg_we);
      else passed++;
      @(negedge clk);
      rst = 1'b0; bus.mem_ready = 1'b0; #1;
      exp_instret = 32'd0;
      checks++;
      if (bus.state !== 3'd0 || bus.instret !== 32'd0 || bus.reg_we !== 1'b0)
         $display("FAIL rst_mid_mem_after: state %0d instret %h reg_we %b expected 0 0 0",
                  bus.state, bus.instret, bus.reg_we);
      else passed++;
   endtask

   task automatic test_wrap();
      @(negedge clk);
      bus.mem_ready = 1'b0;
      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      exp_instret = 32'hFFFF_FFFF;
      #1;
      checks++;
      if (bus.instret !== exp_instret)
         $display("FAIL wrap_preload: instret %h expected %h", bus.instret, exp_instret);
      else passed++;
      run("wrap_r1", OP_R, 3'b000, 1'b0, 0, 0);
      run("wrap_r2", OP_R, 3'b111, 1'b0, 0, 0);
   endtask

   initial begin
      bus.mem_ready = 1'b0; bus.opcode = '0; bus.funct3 = '0; bus.zero = 1'b0;
      test_reset();
      run("lw_zero_wait", OP_LW, 3'b010, 1'b0, 0, 0);
      run("r_type", OP_R, 3'b000, 1'b1, 0, 0);
      run("i_alu", OP_I, 3'b100, 1'b0, 2, 0);
      run("beq_taken", OP_BR, 3'b000, 1'b1, 0, 0);
      run("beq_not_taken", OP_BR, 3'b000, 1'b0, 0, 0);
      run("bne_taken", OP_BR, 3'b001, 1'b0, 0, 0);
      run("bne_not_taken", OP_BR, 3'b001, 1'b1, 1, 0);
      run("sw_mem_wait3", OP_SW, 3'b010, 1'b0, 1, 3);
      run("lw_mem_wait1", OP_LW, 3'b010, 1'b1, 0, 1);
      test_rst_mid_mem();
      test_wrap();
      test_trap("trap_lui", OP_LUI, 3'b000);
      test_trap("trap_br_f3", OP_BR, 3'b100);
      run("post_trap_sw", OP_SW, 3'b010, 1'b0, 0, 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
